// File: rtl/pet_pkg.sv
// Shared glyphs and helpers for the pet needs engine.
// Digits are gfedcba, active-high.
package pet_pkg;

    localparam int FN_W = 8;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    // One extra bit of headroom so the +1 can never wrap before the clamp.
    function automatic logic [FN_W-1:0] clamp_inc(
        input logic [FN_W-1:0] value,
        input logic [FN_W-1:0] ceiling
    );
        logic [FN_W:0] sum;
        sum = {1'b0, value} + (FN_W+1)'(1);
        if (sum > {1'b0, ceiling})
            return ceiling;
        return sum[FN_W-1:0];
    endfunction

endpackage

// File: rtl/pet_seg7_decoder.sv
// Level to 7-segment glyph; values above 15 show a dash.
module pet_seg7_decoder
    import pet_pkg::*;
#(
    parameter int LVL_W = 4
) (
    input  logic [LVL_W-1:0] value,
    output logic [6:0]       seg
);

    logic [15:0] wide;

    assign wide = 16'(value);

    always_comb begin
        seg = SEG_DASH;
        case (wide)
            16'd0:  seg = SEG_0;
            16'd1:  seg = SEG_1;
            16'd2:  seg = SEG_2;
            16'd3:  seg = SEG_3;
            16'd4:  seg = SEG_4;
            16'd5:  seg = SEG_5;
            16'd6:  seg = SEG_6;
            16'd7:  seg = SEG_7;
            16'd8:  seg = SEG_8;
            16'd9:  seg = SEG_9;
            16'd10: seg = SEG_A;
            16'd11: seg = SEG_B;
            16'd12: seg = SEG_C;
            16'd13: seg = SEG_D;
            16'd14: seg = SEG_E;
            16'd15: seg = SEG_F;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/pet_needs_engine.sv
// N-channel pet needs engine: tick decay, button raise, test mode,
// and a registered view of the selected channel.
module pet_needs_engine
    import pet_pkg::*;
#(
    parameter int N_NEEDS   = 4,
    parameter int LVL_W     = 4,
    parameter int LVL_MAX   = 10,
    parameter int LVL_INIT  = 8,
    parameter int HAPPY_THR = 5,
    parameter int PER_W     = 8,
    parameter logic [N_NEEDS*PER_W-1:0] DECAY_PER =
        {8'd50, 8'd70, 8'd100, 8'd120}
) (
    input  logic                         clk,
    input  logic                         btn_reset,
    input  logic                         tick_en,
    input  logic [N_NEEDS-1:0]           btn_need,
    input  logic                         btn_test,
    input  logic [N_NEEDS-1:0]           pause,
    output logic [$clog2(N_NEEDS)-1:0]   sel,
    output logic                         happy,
    output logic [6:0]                   seg,
    output logic [N_NEEDS*LVL_W-1:0]     level_bus,
    output logic                         test_mode,
    output logic                         alarm
);

    localparam int SEL_W = $clog2(N_NEEDS);

    logic [N_NEEDS-1:0] prev_need;
    logic               prev_test;
    logic [N_NEEDS-1:0] rise_need;
    logic               test_rise;
    logic               hit;
    logic [SEL_W-1:0]   ch;
    logic [LVL_W-1:0]   cur;
    logic [LVL_W-1:0]   dec_in;
    logic [6:0]         glyph;
    logic               any_zero;

    // Lowest-index rise wins; the rest are dropped.
    always_comb begin
        hit = |rise_need;
        ch  = '0;
        for (int i = N_NEEDS - 1; i >= 0; i--)
            if (rise_need[i])
                ch = SEL_W'(i);
    end

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            prev_need <= '1;
            prev_test <= 1'b1;
            rise_need <= '0;
            test_rise <= 1'b0;
            sel       <= '0;
            test_mode <= 1'b0;
        end else begin
            prev_need <= btn_need;
            prev_test <= btn_test;
            rise_need <= btn_need & ~prev_need;
            test_rise <= btn_test & ~prev_test;
            if (test_rise)
                test_mode <= ~test_mode;
            if (hit)
                sel <= ch;
        end
    end

    for (genvar i = 0; i < N_NEEDS; i++) begin : g_ch
        localparam logic [PER_W-1:0] PER_M1 =
            DECAY_PER[i*PER_W +: PER_W] - PER_W'(1);

        logic [PER_W-1:0] cnt;
        logic [LVL_W-1:0] lvl;
        logic [LVL_W-1:0] nxt;
        logic             step;
        logic             dec;
        logic             own;

        assign step = !test_mode && !test_rise && tick_en && !pause[i];
        assign dec  = step && (cnt == PER_M1);
        assign own  = hit && (ch == SEL_W'(i)) && (sel == SEL_W'(i));

        // Increment first, then decay, so a press at the ceiling nets -1.
        always_comb begin
            nxt = lvl;
            if (test_mode) begin
                if (own)
                    nxt = (lvl == LVL_W'(1)) ? LVL_W'(LVL_MAX) : LVL_W'(1);
            end else begin
                if (own)
                    nxt = LVL_W'(clamp_inc(FN_W'(lvl), FN_W'(LVL_MAX)));
                if (dec && nxt != '0)
                    nxt = nxt - LVL_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (btn_reset) begin
                cnt <= '0;
                lvl <= LVL_W'(LVL_INIT);
            end else begin
                lvl <= nxt;
                if (test_rise)
                    cnt <= '0;
                else if (step)
                    cnt <= dec ? '0 : cnt + PER_W'(1);
            end
        end

        assign level_bus[i*LVL_W +: LVL_W] = lvl;
    end

    always_comb begin
        cur      = level_bus[0 +: LVL_W];
        any_zero = 1'b0;
        for (int i = 0; i < N_NEEDS; i++) begin
            if (sel == SEL_W'(i))
                cur = level_bus[i*LVL_W +: LVL_W];
            if (level_bus[i*LVL_W +: LVL_W] == '0)
                any_zero = 1'b1;
        end
    end

    // During reset the decoder sees the reset level so outputs reset coherently.
    assign dec_in = btn_reset ? LVL_W'(LVL_INIT) : cur;

    pet_seg7_decoder #(
        .LVL_W (LVL_W)
    ) u_seg (
        .value (dec_in),
        .seg   (glyph)
    );

    always_ff @(posedge clk) begin
        seg   <= glyph;
        happy <= dec_in >= LVL_W'(HAPPY_THR);
        alarm <= !btn_reset && any_zero;
    end

endmodule

// File: tb/tb_pet_needs_engine.sv
// Bench for pet_needs_engine: press table plus decay, reset and
// same-cycle sequences, checked through an expectation queue.
module tb_pet_needs_engine;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int PW = 8;
    localparam logic [N*PW-1:0] PER = {8'd120, 8'd100, 8'd70, 8'd50};

    logic          clk = 1'b0;
    logic          btn_reset;
    logic          tick_en;
    logic [N-1:0]  btn_need;
    logic          btn_test;
    logic [N-1:0]  pause;
    logic [1:0]    sel;
    logic          happy;
    logic [6:0]    seg;
    logic [N*LW-1:0] level_bus;
    logic          test_mode;
    logic          alarm;

    always #5 clk = ~clk;

    pet_needs_engine #(
        .DECAY_PER (PER)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .tick_en   (tick_en),
        .btn_need  (btn_need),
        .btn_test  (btn_test),
        .pause     (pause),
        .sel       (sel),
        .happy     (happy),
        .seg       (seg),
        .level_bus (level_bus),
        .test_mode (test_mode),
        .alarm     (alarm)
    );

    typedef struct {
        string       name;
        logic [15:0] bus;
        logic [1:0]  sel;
        logic        tm;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  need;
        logic        test;
        logic [15:0] bus;
        logic [1:0]  sel;
        logic        tm;
    } row_t;

    exp_t sb[$];
    row_t rows[13];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0:  return 7'b0111111;
            4'd1:  return 7'b0000110;
            4'd2:  return 7'b1011011;
            4'd3:  return 7'b1001111;
            4'd4:  return 7'b1100110;
            4'd5:  return 7'b1101101;
            4'd6:  return 7'b1111101;
            4'd7:  return 7'b0000111;
            4'd8:  return 7'b1111111;
            4'd9:  return 7'b1101111;
            4'd10: return 7'b1110111;
            4'd11: return 7'b1111100;
            4'd12: return 7'b0111001;
            4'd13: return 7'b1011110;
            4'd14: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input string name, input logic [15:0] bus,
                        input logic [1:0] s, input logic tm);
        exp_t e;
        e.name = name;
        e.bus  = bus;
        e.sel  = s;
        e.tm   = tm;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] cur;
        logic       zero;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            cur  = e.bus[e.sel*4 +: 4];
            zero = 1'b0;
            for (int i = 0; i < N; i++)
                if (e.bus[i*4 +: 4] == 4'd0)
                    zero = 1'b1;
            cmp({e.name, ".bus"}, level_bus, e.bus);
            cmp({e.name, ".sel"}, 16'(sel), 16'(e.sel));
            cmp({e.name, ".seg"}, 16'(seg), 16'(ref_glyph(cur)));
            cmp({e.name, ".happy"}, 16'(happy), 16'(cur >= 4'd5));
            cmp({e.name, ".alarm"}, 16'(alarm), 16'(zero));
            cmp({e.name, ".test"}, 16'(test_mode), 16'(e.tm));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        tick_en = 1'b1;
        cyc(n);
        tick_en = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] need, input logic test);
        btn_need = need;
        btn_test = test;
        cyc(1);
        btn_need = '0;
        btn_test = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        btn_reset = 1'b1;
        cyc(2);
        btn_reset = 1'b0;
        cyc(3);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            push(rows[r].name, rows[r].bus, rows[r].sel, rows[r].tm);
            pulse(rows[r].need, rows[r].test);
            drain();
        end
    endtask

    // Press lands on the same edge as channel 0's 50th tick.
    task automatic aligned_press();
        tick_en = 1'b1;
        cyc(48);
        btn_need = 4'b0001;
        cyc(1);
        btn_need = '0;
        cyc(1);
        tick_en = 1'b0;
        cyc(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rows[0]  = '{"sel2",    4'b0100, 1'b0, 16'h8888, 2'd2, 1'b0};
        rows[1]  = '{"inc9",    4'b0100, 1'b0, 16'h8988, 2'd2, 1'b0};
        rows[2]  = '{"inc10",   4'b0100, 1'b0, 16'h8A88, 2'd2, 1'b0};
        rows[3]  = '{"sat10",   4'b0100, 1'b0, 16'h8A88, 2'd2, 1'b0};
        rows[4]  = '{"arb13",   4'b1010, 1'b0, 16'h8A88, 2'd1, 1'b0};
        rows[5]  = '{"sel3",    4'b1000, 1'b0, 16'h8A88, 2'd3, 1'b0};
        rows[6]  = '{"inc3",    4'b1000, 1'b0, 16'h9A88, 2'd3, 1'b0};
        rows[7]  = '{"test_on", 4'b0000, 1'b1, 16'h9A88, 2'd3, 1'b1};
        rows[8]  = '{"t_sel0",  4'b0001, 1'b0, 16'h9A88, 2'd0, 1'b1};
        rows[9]  = '{"t_to1",   4'b0001, 1'b0, 16'h9A81, 2'd0, 1'b1};
        rows[10] = '{"t_to10",  4'b0001, 1'b0, 16'h9A8A, 2'd0, 1'b1};
        rows[11] = '{"t_to1b",  4'b0001, 1'b0, 16'h9A81, 2'd0, 1'b1};
        rows[12] = '{"test_off",4'b0000, 1'b1, 16'h9A81, 2'd0, 1'b0};

        btn_reset = 1'b1;
        tick_en   = 1'b0;
        btn_need  = '0;
        btn_test  = 1'b0;
        pause     = '0;
        cyc(2);
        btn_reset = 1'b0;
        cyc(3);
        push("reset", 16'h8888, 2'd0, 1'b0);
        drain();

        run_rows(0, 6);
        // Partial counts here must be wiped by the test-mode toggles.
        push("pre_test_ticks", 16'h9A88, 2'd3, 1'b0);
        tick(30);
        cyc(1);
        drain();
        run_rows(7, 7);
        push("test_no_decay", 16'h9A88, 2'd3, 1'b1);
        tick(500);
        cyc(1);
        drain();
        run_rows(8, 12);
        push("clr_49", 16'h9A81, 2'd0, 1'b0);
        tick(49);
        cyc(1);
        drain();
        push("clr_50", 16'h9A80, 2'd0, 1'b0);
        tick(1);
        cyc(1);
        drain();

        do_reset();
        push("decay_399", 16'h5531, 2'd0, 1'b0);
        tick(399);
        cyc(1);
        drain();
        push("decay_400", 16'h5430, 2'd0, 1'b0);
        tick(1);
        cyc(1);
        drain();
        push("decay_500", 16'h4310, 2'd0, 1'b0);
        tick(100);
        cyc(1);
        drain();

        // Reset mid-decay with a button held through and past reset.
        btn_need  = 4'b0001;
        tick_en   = 1'b1;
        btn_reset = 1'b1;
        cyc(2);
        btn_reset = 1'b0;
        tick_en   = 1'b0;
        cyc(3);
        push("rst_held", 16'h8888, 2'd0, 1'b0);
        drain();
        btn_need = '0;
        cyc(3);
        push("rst_release", 16'h8888, 2'd0, 1'b0);
        drain();
        push("rst_press", 16'h8889, 2'd0, 1'b0);
        pulse(4'b0001, 1'b0);
        drain();

        do_reset();
        pause = 4'b0001;
        push("pause0", 16'h8778, 2'd0, 1'b0);
        tick(100);
        cyc(1);
        drain();
        pause = '0;

        do_reset();
        push("pre9", 16'h8889, 2'd0, 1'b0);
        pulse(4'b0001, 1'b0);
        drain();
        push("same_at9", 16'h8889, 2'd0, 1'b0);
        aligned_press();
        drain();
        push("pre10", 16'h888A, 2'd0, 1'b0);
        pulse(4'b0001, 1'b0);
        drain();
        push("same_at10", 16'h8779, 2'd0, 1'b0);
        aligned_press();
        drain();
        push("after_49", 16'h7769, 2'd0, 1'b0);
        tick(49);
        cyc(1);
        drain();
        push("after_50", 16'h7768, 2'd0, 1'b0);
        tick(1);
        cyc(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pet_needs_engine.md
Name: pet_needs_engine

Overview:
Parametrised successor to the single-pet needs FSM. It manages N independent need levels: decay on a shared tick strobe, per-channel button raise with edge detection, and a test mode. It drives a selected-channel 7-segment digit, a happy/sad flag and a packed level bus. It sits between the debounced button conditioner and the display/LCD face renderer.

Parameters:
N_NEEDS, 4, number of need channels (2..8)
LVL_W, 4, level register width
LVL_MAX, 10, saturation ceiling; must be < 2**LVL_W
LVL_INIT, 8, level loaded on reset
HAPPY_THR, 5, level >= HAPPY_THR gives happy=1
PER_W, 8, decay-period counter width
DECAY_PER, {8'd50,8'd70,8'd100,8'd120}, packed N_NEEDS*PER_W; channel i period = slice i (ticks per decrement), each >= 1

Ports:
clk  in  1  system clock
btn_reset  in  1  synchronous active-high reset
tick_en  in  1  one-cycle decay time-base strobe
btn_need  in  N_NEEDS  debounced level buttons, one per channel
btn_test  in  1  debounced test-mode toggle button
pause  in  N_NEEDS  per-channel decay freeze (e.g. sleeping freezes energy)
sel  out  $clog2(N_NEEDS)  currently displayed channel
happy  out  1  selected level >= HAPPY_THR
seg  out  7  gfedcba active-high digit of the selected level
level_bus  out  N_NEEDS*LVL_W  all levels; channel i at [i*LVL_W +: LVL_W]
test_mode  out  1  test mode active
alarm  out  1  any level == 0

Behaviour:
- One clock `clk`; reset `btn_reset` is synchronous and active-high. Reset dominates all other inputs in the same cycle.
- Reset values: all levels=LVL_INIT, decay counters=0, sel=0, test_mode=0, alarm=0. happy and seg are those of LVL_INIT. Edge-detect history regs are set to all-1 so buttons held through reset do not fire.
- Edge detect: a press is rise = btn & ~prev, registered per button. Action happens in the cycle after the rise is seen, so level/sel update 1 cycle after the rising input sample.
- Press arbitration: if several channel rises occur in one cycle, the lowest index wins and the others are dropped.
- Normal mode, press on channel c:
  - if sel != c: sel<=c only (first press selects, no level change);
  - if sel == c: level[c] <= min(level[c]+1, LVL_MAX).
- Test mode, press on channel c: sel<=c. If sel was already c, level[c] toggles: ==1 -> LVL_MAX; else -> 1.
- btn_test rise toggles test_mode. On entering or leaving test mode, all decay counters clear. Levels are kept.
- Decay, normal mode only: on tick_en with pause[i]=0, counter[i]++. When counter[i]==DECAY_PER[i]-1, the counter clears and level[i] decrements, saturating at 0. pause[i]=1 holds counter[i]. No decay at all in test mode.
- Same-cycle press-increment and decrement on one channel: net level unchanged, counter still clears. At LVL_MAX this gives LVL_MAX-1.
- Outputs happy, seg and alarm are registered, valid 1 cycle after the level/sel change (2 cycles after the button input).
- seg encoding: 0-9 decimal glyphs, 10-15 hex A,b,C,d,E,F, >15 shows '-' (7'b1000000).
- Width rule: all comparisons are unsigned at LVL_W. Increment is computed at LVL_W+1 before saturation, so there is no wrap.

Decomposition:
- Package pet_pkg: 7-seg glyph constants, SEG_DASH, and a function clamp_inc.
- Sub-module pet_seg7_decoder: combinational, LVL_W in, 7 out, instantiated once.
- Per-channel decay counter is a generate loop, not a separate module.

Test Plan:
- Reset, then idle 3 cycles -> level_bus=16'h8888, sel=0, seg=7'b1111111, happy=1, alarm=0.
- Rise btn_need[2] twice (release between) -> after 1st press: sel=2, level[2]=8. After 2nd: level[2]=9, seg=7'b1101111. Two more presses -> 10, then stays 10 (seg=7'b1110111).
- Drive tick_en=1 continuously with pause=0 -> level[0] drops every 50 cycles. From 8 it reaches 0 after 400 cycles and alarm=1. Further ticks keep it at 0. pause[0]=1 halts channel 0 only.
- btn_need[1] and btn_need[3] rise in the same cycle -> sel=1 only, level[3] unchanged.
- btn_test rise, then press channel 0 twice -> test_mode=1, level[0]=1. 3rd press -> 10, 4th -> 1. 500 ticks -> no decay. btn_test again -> test_mode=0, counters at 0.
- btn_reset asserted mid-decay with btn_need[0] held -> all state back to reset values. Releasing reset with the button still held gives no press. Same-cycle increment+decay at level 10 -> 9.
